// File: rtl/prom_ram_banked.sv
// Banked dual-port RAM with req/gnt handshake, per-byte write enables,
// two-stage read pipeline and a hardware clear engine that zeroes every
// bank after reset or on request.
module prom_ram_banked #(
  parameter int DATA_W      = 8,
  parameter int BANK_ADDR_W = 12,
  parameter int NUM_BANKS   = 5,
  parameter int BANK_SEL_W  = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr_req,
  output logic                                busy,
  input  logic                                a_req,
  input  logic                                a_we,
  input  logic [DATA_W/8-1:0]                 a_be,
  input  logic [BANK_SEL_W+BANK_ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]                   a_wdata,
  output logic                                a_gnt,
  output logic                                a_rvalid,
  output logic [DATA_W-1:0]                   a_rdata,
  output logic                                a_err,
  input  logic                                b_req,
  input  logic                                b_we,
  input  logic [DATA_W/8-1:0]                 b_be,
  input  logic [BANK_SEL_W+BANK_ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]                   b_wdata,
  output logic                                b_gnt,
  output logic                                b_rvalid,
  output logic [DATA_W-1:0]                   b_rdata,
  output logic                                b_err
);

  localparam int ADDR_W = BANK_SEL_W + BANK_ADDR_W;
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 2 ** BANK_ADDR_W;
  localparam logic [BANK_SEL_W:0] NB = (BANK_SEL_W + 1)'(NUM_BANKS);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                 state_reg, state_next;
  logic [BANK_ADDR_W-1:0] cnt_reg, cnt_next;
  logic                   prio_reg;   // 0 = port A wins a write conflict, 1 = port B

  // Address decode
  logic [BANK_SEL_W-1:0]  a_bank, b_bank;
  logic [BANK_ADDR_W-1:0] a_word, b_word;
  logic                   a_in, b_in;
  logic                   conflict, lose_a, lose_b;
  logic                   a_rd, b_rd, a_wr, b_wr;

  assign a_bank = a_addr[ADDR_W-1:BANK_ADDR_W];
  assign b_bank = b_addr[ADDR_W-1:BANK_ADDR_W];
  assign a_word = a_addr[BANK_ADDR_W-1:0];
  assign b_word = b_addr[BANK_ADDR_W-1:0];
  assign a_in   = ({1'b0, a_bank} < NB);
  assign b_in   = ({1'b0, b_bank} < NB);

  // Only two writes to the same in-range word collide; everything else runs in parallel.
  assign conflict = a_req & b_req & a_we & b_we & (a_addr == b_addr) & a_in;
  assign lose_a   = conflict & prio_reg;
  assign lose_b   = conflict & ~prio_reg;

  assign busy  = (state_reg == ST_CLEAR);
  assign a_gnt = a_req & ~busy & ~lose_a;
  assign b_gnt = b_req & ~busy & ~lose_b;
  assign a_rd  = a_gnt & ~a_we;
  assign b_rd  = b_gnt & ~b_we;
  assign a_wr  = a_gnt & a_we & a_in;
  assign b_wr  = b_gnt & b_we & b_in;

  // Clear FSM state, word counter and conflict priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_CLEAR;
      cnt_reg   <= '0;
      prio_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (conflict && !busy) prio_reg <= ~prio_reg;
    end
  end

  // Next-state logic: sweep every word once, then idle until a clear request
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == {BANK_ADDR_W{1'b1}}) state_next = ST_IDLE;
      end
      default: begin
        if (clr_req) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
    endcase
  end

  // Per-bank registered read outputs (stage 1)
  logic [DATA_W-1:0] a_bank_q [NUM_BANKS];
  logic [DATA_W-1:0] b_bank_q [NUM_BANKS];

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic              a_hit, b_hit;

    assign a_hit = (a_bank == BANK_SEL_W'(gi));
    assign b_hit = (b_bank == BANK_SEL_W'(gi));

    // Read-first bank: reads sample the old word, clear or lane writes update it
    always_ff @(posedge clk) begin
      if (a_rd && a_hit) a_bank_q[gi] <= mem[a_word];
      if (b_rd && b_hit) b_bank_q[gi] <= mem[b_word];
      if (busy) begin
        mem[cnt_reg] <= '0;
      end else begin
        for (int i = 0; i < BE_W; i++) begin
          if (a_wr && a_hit && a_be[i]) mem[a_word][8*i +: 8] <= a_wdata[8*i +: 8];
          if (b_wr && b_hit && b_be[i]) mem[b_word][8*i +: 8] <= b_wdata[8*i +: 8];
        end
      end
    end
  end

  // Stage-1 side info travelling with the bank read
  logic                  a_v1, b_v1, a_err1, b_err1;
  logic [BANK_SEL_W-1:0] a_sel1, b_sel1;
  logic [DATA_W-1:0]     a_mux, b_mux;

  // Bank-select mux feeding the output register
  always_comb begin
    a_mux = '0;
    b_mux = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (a_sel1 == BANK_SEL_W'(i)) a_mux = a_bank_q[i];
      if (b_sel1 == BANK_SEL_W'(i)) b_mux = b_bank_q[i];
    end
  end

  // Read pipeline: stage 1 tags, stage 2 output register with valid strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v1     <= 1'b0;
      a_sel1   <= '0;
      a_err1   <= 1'b0;
      b_v1     <= 1'b0;
      b_sel1   <= '0;
      b_err1   <= 1'b0;
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      a_err    <= 1'b0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
      b_err    <= 1'b0;
    end else begin
      a_v1     <= a_rd;
      b_v1     <= b_rd;
      a_rvalid <= a_v1;
      b_rvalid <= b_v1;
      if (a_rd) begin
        a_sel1 <= a_bank;
        a_err1 <= ~a_in;
      end
      if (b_rd) begin
        b_sel1 <= b_bank;
        b_err1 <= ~b_in;
      end
      if (a_v1) begin
        a_rdata <= a_err1 ? '0 : a_mux;
        a_err   <= a_err1;
      end
      if (b_v1) begin
        b_rdata <= b_err1 ? '0 : b_mux;
        b_err   <= b_err1;
      end
    end
  end

endmodule
